// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction fields in, stall/flush/forwarding controls
// and event counters out. The pipeline side uses master, the controller uses slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(STAGES + 1)
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_branch;
  logic              id_taken;
  logic              id_regw;
  logic [REG_AW-1:0] id_dest;
  logic              id_load;
  logic              ext_hold;
  logic              stall;
  logic              flush_ifid;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
           id_regw, id_dest, id_load, ext_hold,
    input  stall, flush_ifid, fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
           id_regw, id_dest, id_load, ext_hold,
    output stall, flush_ifid, fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline (branches resolved in ID).
// Optional feature macro: HAZARD_BRANCH_EX_FWD_EN (ID branch compares may forward from EX).
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dest;
    logic              load;
  } ent_t;

  ent_t             sb_q [STAGES];
  ent_t             sb_d [STAGES];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  logic [STAGES-1:0] rs_m_s;
  logic [STAGES-1:0] rt_m_s;
  logic [SEL_W-1:0]  rs_raw_s;
  logic [SEL_W-1:0]  rt_raw_s;
  logic              ex_hit_s;
  logic              load_use_s;
  logic              br_dep_s;
  logic              haz_s;
  logic              stall_s;
  logic              flush_s;

  // Lowest-index match wins: scan from the top so the lowest index is written last.
  function automatic logic [SEL_W-1:0] first_sel(input logic [STAGES-1:0] m);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      sel = m[k] ? SEL_W'(k + 1) : sel;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Per-entry source matches against the in-flight destinations.
  always_comb begin
    rs_m_s = '0;
    rt_m_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      rs_m_s[k] = bus.id_use_rs & sb_q[k].v & (sb_q[k].dest == bus.id_rs);
      rt_m_s[k] = bus.id_use_rt & sb_q[k].v & (sb_q[k].dest == bus.id_rt);
    end
  end

  // Stall/flush decision from the winning entries.
  always_comb begin
    rs_raw_s   = first_sel(rs_m_s);
    rt_raw_s   = first_sel(rt_m_s);
    ex_hit_s   = (rs_raw_s == SEL_W'(1)) | (rt_raw_s == SEL_W'(1));
    load_use_s = ex_hit_s & sb_q[0].load;
`ifdef HAZARD_BRANCH_EX_FWD_EN
    br_dep_s   = 1'b0;
`else
    br_dep_s   = bus.id_branch & ex_hit_s & ~sb_q[0].load;
`endif
    haz_s      = load_use_s | br_dep_s;
    stall_s    = bus.ext_hold | haz_s;
    flush_s    = bus.id_valid & bus.id_taken & ~stall_s;
  end

  assign bus.stall      = stall_s;
  assign bus.flush_ifid = flush_s;
  assign bus.fwd_rs_sel = haz_s ? '0 : rs_raw_s;
  assign bus.fwd_rt_sel = haz_s ? '0 : rt_raw_s;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

  // Scoreboard shift and counter update; a hazard stall inserts a bubble at EX.
  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.ext_hold) begin
      sb_d        = sb_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      if (haz_s) begin
        sb_d[0]     = '0;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        sb_d[0].v    = bus.id_valid & bus.id_regw & (bus.id_dest != '0);
        sb_d[0].dest = bus.id_dest;
        sb_d[0].load = bus.id_load;
        stall_cnt_d  = stall_cnt_q;
      end
      flush_cnt_d = flush_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: instruction steps push expected outputs to a
// queue, which is popped and compared at the falling edge of the same cycle.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int STAGES = 3;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs;
    logic              urs;
    logic [REG_AW-1:0] rt;
    logic              urt;
    logic              br;
    logic              tk;
    logic              rw;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } ins_t;

  typedef struct {
    logic stall;
    logic flush;
    int   rs_sel;
    int   rt_sel;
    int   sc;
    int   fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   sc_exp;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t bub();
    return '0;
  endfunction

  function automatic ins_t alu(input int d, input int s, input logic us, input int t, input logic ut);
    ins_t i = '0;
    i.v = 1'b1; i.rw = 1'b1; i.dst = REG_AW'(d);
    i.rs = REG_AW'(s); i.urs = us; i.rt = REG_AW'(t); i.urt = ut;
    return i;
  endfunction

  function automatic ins_t lw(input int d, input int base);
    ins_t i = alu(d, base, 1'b1, 0, 1'b0);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t beq(input int s, input int t, input logic tk);
    ins_t i = '0;
    i.v = 1'b1; i.br = 1'b1; i.tk = tk;
    i.rs = REG_AW'(s); i.urs = 1'b1; i.rt = REG_AW'(t); i.urt = 1'b1;
    return i;
  endfunction

  function automatic ins_t jr(input int s);
    ins_t i = '0;
    i.v = 1'b1; i.tk = 1'b1; i.rs = REG_AW'(s); i.urs = 1'b1;
    return i;
  endfunction

  task automatic step(input string tag, input logic rst_v, input ins_t i, input logic hold,
                      input logic es, input logic ef, input int ers, input int ert,
                      input int esc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = rst_v;
    bus.id_valid  = i.v;
    bus.id_rs     = i.rs;
    bus.id_use_rs = i.urs;
    bus.id_rt     = i.rt;
    bus.id_use_rt = i.urt;
    bus.id_branch = i.br;
    bus.id_taken  = i.tk;
    bus.id_regw   = i.rw;
    bus.id_dest   = i.dst;
    bus.id_load   = i.ld;
    bus.ext_hold  = hold;
    e.stall = es; e.flush = ef; e.rs_sel = ers; e.rt_sel = ert; e.sc = esc; e.fc = efc;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "/stall"},  32'(bus.stall),      32'(e.stall));
    chk({tag, "/flush"},  32'(bus.flush_ifid), 32'(e.flush));
    chk({tag, "/rs_sel"}, 32'(bus.fwd_rs_sel), 32'(e.rs_sel));
    chk({tag, "/rt_sel"}, 32'(bus.fwd_rt_sel), 32'(e.rt_sel));
    chk({tag, "/scnt"},   32'(bus.stall_cnt),  32'(e.sc));
    chk({tag, "/fcnt"},   32'(bus.flush_cnt),  32'(e.fc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_use_rs = 1'b0; bus.id_rt = '0;
    bus.id_use_rt = 1'b0; bus.id_branch = 1'b0; bus.id_taken = 1'b0; bus.id_regw = 1'b0;
    bus.id_dest = '0; bus.id_load = 1'b0; bus.ext_hold = 1'b0;

    step("reset",     1'b0, bub(),                    1'b0, 0, 0, 0, 0, 0, 0);
    // ALU forwarding: EX then WB-bound distance.
    step("add3",      1'b1, alu(3, 1, 1, 2, 1),       1'b0, 0, 0, 0, 0, 0, 0);
    step("sub_rs3",   1'b1, alu(6, 3, 1, 1, 1),       1'b0, 0, 0, 1, 0, 0, 0);
    step("or_rt3",    1'b1, alu(7, 2, 1, 3, 1),       1'b0, 0, 0, 0, 2, 0, 0);
    // Load-use: one stall, then forward from MEM.
    step("lw5",       1'b1, lw(5, 2),                 1'b0, 0, 0, 0, 0, 0, 0);
    step("lu_stall",  1'b1, alu(8, 3, 1, 5, 1),       1'b0, 1, 0, 0, 0, 0, 0);
    step("lu_fwd",    1'b1, alu(8, 3, 1, 5, 1),       1'b0, 0, 0, 0, 2, 1, 0);
    step("addi4",     1'b1, alu(4, 0, 0, 0, 0),       1'b0, 0, 0, 0, 0, 1, 0);
`ifdef HAZARD_BRANCH_EX_FWD_EN
    step("beq4_fwd",  1'b1, beq(4, 9, 1'b0),          1'b0, 0, 0, 1, 0, 1, 0);
    sc_exp = 1;
`else
    step("beq4_stl",  1'b1, beq(4, 9, 1'b0),          1'b0, 1, 0, 0, 0, 1, 0);
    step("beq4_fwd",  1'b1, beq(4, 9, 1'b0),          1'b0, 0, 0, 2, 0, 2, 0);
    sc_exp = 2;
`endif
    // Taken branch without dependency flushes once.
    step("beq_tk",    1'b1, beq(10, 11, 1'b1),        1'b0, 0, 1, 0, 0, sc_exp, 0);
    step("flushed",   1'b1, bub(),                    1'b0, 0, 0, 0, 0, sc_exp, 1);
    // Taken branch behind a load: stall wins, flush follows.
    step("lw12",      1'b1, lw(12, 0),                1'b0, 0, 0, 0, 0, sc_exp, 1);
    step("brld_stl",  1'b1, beq(12, 0, 1'b1),         1'b0, 1, 0, 0, 0, sc_exp, 1);
    step("brld_fl",   1'b1, beq(12, 0, 1'b1),         1'b0, 0, 1, 2, 0, sc_exp + 1, 1);
    step("flushed2",  1'b1, bub(),                    1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    // Register $0 never tracked.
    step("wr_r0",     1'b1, alu(0, 1, 0, 1, 0),       1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    step("use_r0",    1'b1, alu(9, 0, 1, 0, 1),       1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    step("lw_r0",     1'b1, lw(0, 1),                 1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    step("use_r0_ld", 1'b1, alu(9, 0, 1, 0, 1),       1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    // External hold alone: stall, no flush, forwarding still visible.
    step("add14",     1'b1, alu(14, 0, 0, 0, 0),      1'b0, 0, 0, 0, 0, sc_exp + 1, 2);
    step("jr_hold",   1'b1, jr(14),                   1'b1, 1, 0, 1, 0, sc_exp + 1, 2);
    step("jr_go",     1'b1, jr(14),                   1'b0, 0, 1, 1, 0, sc_exp + 1, 2);
    step("flushed3",  1'b1, bub(),                    1'b0, 0, 0, 0, 0, sc_exp + 1, 3);
    // Hold during a load-use for 3 cycles, then reset mid-stall.
    step("lw13",      1'b1, lw(13, 0),                1'b0, 0, 0, 0, 0, sc_exp + 1, 3);
    for (int h = 0; h < 3; h++) begin
      step("hold_lu", 1'b1, alu(15, 13, 1, 0, 0),     1'b1, 1, 0, 0, 0, sc_exp + 1, 3);
    end
    step("rst_mid",   1'b0, alu(15, 13, 1, 0, 0),     1'b0, 0, 0, 0, 0, 0, 0);
    step("rst_flush", 1'b0, beq(1, 2, 1'b1),          1'b0, 0, 1, 0, 0, 0, 0);
    step("post_rst",  1'b1, alu(3, 0, 0, 0, 0),       1'b0, 0, 0, 0, 0, 0, 0);
    step("post_fwd",  1'b1, alu(5, 3, 1, 0, 0),       1'b0, 0, 0, 1, 0, 0, 0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
